// File: rtl/zap_reset_sequencer_if.sv
// zap_reset_sequencer_if: request, init-status and domain-reset signals of the
// staged reset sequencer.
//   i_sw_reset_req   software reset request (single-cycle pulse)
//   i_wdt_reset_req  watchdog reset request (level)
//   i_mem_init_done  cache/TLB invalidate complete (level)
//   o_reset_periph   peripheral domain reset, active high
//   o_reset_mem      cache/MMU domain reset, active high
//   o_reset_core     core pipeline reset, active high
//   o_busy           sequence in progress
//   o_reset_cause    01 external, 10 software, 11 watchdog
//   o_init_err       init timeout seen during the last sequence
// slave: the sequencer; master: the surrounding SoC / testbench.
interface zap_reset_sequencer_if;
  logic       i_sw_reset_req;
  logic       i_wdt_reset_req;
  logic       i_mem_init_done;
  logic       o_reset_periph;
  logic       o_reset_mem;
  logic       o_reset_core;
  logic       o_busy;
  logic [1:0] o_reset_cause;
  logic       o_init_err;

  modport slave (
    input  i_sw_reset_req, i_wdt_reset_req, i_mem_init_done,
    output o_reset_periph, o_reset_mem, o_reset_core, o_busy,
           o_reset_cause, o_init_err
  );

  modport master (
    output i_sw_reset_req, i_wdt_reset_req, i_mem_init_done,
    input  o_reset_periph, o_reset_mem, o_reset_core, o_busy,
           o_reset_cause, o_init_err
  );
endinterface

// File: rtl/zap_reset_sequencer.sv
// zap_reset_sequencer: holds all ZAP reset domains for MIN_ASSERT cycles after
// the last request, then releases peripherals, memory subsystem and core in
// that order, STAGE_GAP cycles apart, waiting (up to INIT_TIMEOUT cycles) for
// cache/TLB init before the core stage. Records the cause of the last reset.
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset, also the external reset request
//   bus      zap_reset_sequencer_if.slave (requests, init done, domain resets,
//            busy, cause, init error); all outputs registered
module zap_reset_sequencer #(
  parameter int unsigned MIN_ASSERT   = 8,
  parameter int unsigned STAGE_GAP    = 4,
  parameter int unsigned INIT_TIMEOUT = 256
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  zap_reset_sequencer_if.slave   bus
);

  localparam int unsigned MAX_A   = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
  localparam int unsigned MAX_CNT = (MAX_A > INIT_TIMEOUT) ? MAX_A : INIT_TIMEOUT;
  localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_REL_MEM,
    ST_WAIT_INIT,
    ST_REL_CORE,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, periph_d;
  logic             mem_q, mem_d;
  logic             core_q, core_d;
  logic             busy_q, busy_d;
  logic [1:0]       cause_q, cause_d;
  logic             err_q, err_d;
  logic             req;

  assign req = i_reset | bus.i_sw_reset_req | bus.i_wdt_reset_req;

  // Next-state and next-output logic; a request overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    mem_d    = mem_q;
    core_d   = core_q;
    cause_d  = cause_q;
    err_d    = err_q;

    if (req) begin
      state_d  = ST_ASSERT;
      cnt_d    = '0;
      periph_d = 1'b1;
      mem_d    = 1'b1;
      core_d   = 1'b1;
      err_d    = 1'b0;
      if (i_reset)                  cause_d = CAUSE_EXT;
      else if (bus.i_wdt_reset_req) cause_d = CAUSE_WDT;
      else                          cause_d = CAUSE_SW;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          periph_d = 1'b1;
          mem_d    = 1'b1;
          core_d   = 1'b1;
          if (cnt_q == ASSERT_LAST) begin
            periph_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_REL_MEM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_MEM: begin
          if (cnt_q == GAP_LAST) begin
            mem_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_WAIT_INIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_INIT: begin
          if (bus.i_mem_init_done || (cnt_q == TIMEOUT_LAST)) begin
            // Timeout only counts as an error if init did not finish on that edge.
            if (!bus.i_mem_init_done) err_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_REL_CORE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_CORE: begin
          if (cnt_q == GAP_LAST) begin
            core_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          periph_d = 1'b0;
          mem_d    = 1'b0;
          core_d   = 1'b0;
          cnt_d    = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      mem_q    <= 1'b1;
      core_q   <= 1'b1;
      busy_q   <= 1'b1;
      cause_q  <= CAUSE_EXT;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      mem_q    <= mem_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_reset_periph = periph_q;
  assign bus.o_reset_mem    = mem_q;
  assign bus.o_reset_core   = core_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_reset_cause  = cause_q;
  assign bus.o_init_err     = err_q;

endmodule

// File: tb/tb_zap_reset_sequencer.sv
// tb_zap_reset_sequencer: directed bench for the staged reset sequencer.
// Output vector compared each step is {periph, mem, core, busy, init_err}.
module tb_zap_reset_sequencer;

  localparam int MA = 8;
  localparam int SG = 4;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [63:0] pulse_mask;

  zap_reset_sequencer_if ifc ();

  zap_reset_sequencer #(
    .MIN_ASSERT  (MA),
    .STAGE_GAP   (SG),
    .INIT_TIMEOUT(TO)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, ifc.o_reset_periph, ifc.o_reset_mem, ifc.o_reset_core,
            ifc.o_busy, ifc.o_init_err};
  endfunction

  // Walk edges k = 1..last_k after the request drops, driving init_done from mask.
  task automatic sched(input string tag, input int core_k, input int err_k,
                       input logic [63:0] mask, input int last_k);
    logic [7:0] exp;
    for (int k = 1; k <= last_k; k++) begin
      ifc.i_mem_init_done = mask[k];
      tick();
      exp = {3'b000, 1'(k < MA), 1'(k < MA + SG), 1'(k < core_k), 1'(k < core_k),
             1'((err_k > 0) && (k >= err_k))};
      chk($sformatf("%s k=%0d", tag, k), outs(), exp);
    end
  endtask

  task automatic sw_pulse();
    ifc.i_sw_reset_req = 1'b1;
    tick();
    ifc.i_sw_reset_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst                 = 1'b1;
    ifc.i_sw_reset_req  = 1'b0;
    ifc.i_wdt_reset_req = 1'b0;
    ifc.i_mem_init_done = 1'b1;

    // Power-on reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("por_hold", outs(), 8'h1E);
      chk("por_cause", 8'(ifc.o_reset_cause), 8'h01);
    end
    rst = 1'b0;
    sched("por", 17, 0, '1, 17);
    chk("por_cause_end", 8'(ifc.o_reset_cause), 8'h01);

    // Software pulse from RUN.
    sw_pulse();
    chk("sw_assert", outs(), 8'h1E);
    chk("sw_cause", 8'(ifc.o_reset_cause), 8'h02);
    sched("sw", 17, 0, '1, 17);

    // Watchdog held 20 cycles while in REL_MEM.
    sw_pulse();
    sched("pre_wdt", 17, 0, '1, 9);
    ifc.i_wdt_reset_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("wdt_hold %0d", i), outs(), 8'h1E);
    end
    chk("wdt_cause", 8'(ifc.o_reset_cause), 8'h03);
    ifc.i_wdt_reset_req = 1'b0;
    sched("wdt", 17, 0, '1, 17);
    chk("wdt_cause_end", 8'(ifc.o_reset_cause), 8'h03);

    // Init never completes: timeout after 16 WAIT_INIT edges, core 4 later.
    sw_pulse();
    sched("timeout", 32, 28, '0, 32);
    chk("timeout_cause", 8'(ifc.o_reset_cause), 8'h02);
    ifc.i_mem_init_done = 1'b1;
    sw_pulse();
    chk("err_clear", outs(), 8'h1E);
    sched("post_to", 17, 0, '1, 17);

    // Simultaneous requests: cause priority.
    rst                 = 1'b1;
    ifc.i_wdt_reset_req = 1'b1;
    ifc.i_sw_reset_req  = 1'b1;
    tick();
    chk("all3_cause", 8'(ifc.o_reset_cause), 8'h01);
    chk("all3_out", outs(), 8'h1E);
    rst = 1'b0;
    tick();
    chk("wdt_sw_cause", 8'(ifc.o_reset_cause), 8'h03);
    ifc.i_wdt_reset_req = 1'b0;
    ifc.i_sw_reset_req  = 1'b0;

    // Single-cycle init_done pulses: ignored in ASSERT (k=3) and REL_MEM (k=10),
    // accepted at WAIT_INIT t=5 (k=17), core falls at 21.
    pulse_mask     = '0;
    pulse_mask[3]  = 1'b1;
    pulse_mask[10] = 1'b1;
    pulse_mask[17] = 1'b1;
    sched("pulse", 21, 0, pulse_mask, 21);
    chk("pulse_cause", 8'(ifc.o_reset_cause), 8'h03);

    // Request on the same edge as the final core release wins.
    ifc.i_mem_init_done = 1'b1;
    sw_pulse();
    sched("coinc", 17, 0, '1, 16);
    ifc.i_sw_reset_req = 1'b1;
    tick();
    ifc.i_sw_reset_req = 1'b0;
    chk("coinc_req", outs(), 8'h1E);
    chk("coinc_cause", 8'(ifc.o_reset_cause), 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zap_reset_sequencer.md
# zap_reset_sequencer

Staged reset controller for the ZAP core. It takes the already-synchronized global reset plus software and watchdog reset requests, and holds every reset domain asserted for a minimum time. It then releases the domains in a fixed order (peripherals, then memory subsystem, then core), waiting for cache/TLB initialization to complete before letting the core out of reset. It sits between the reset synchronizer output and the per-domain reset inputs of the core, cache/MMU and peripheral blocks, and records the cause of the last reset.

## Interface
- MIN_ASSERT, 8: cycles all domains stay asserted after the last active request; must be ≥ 2.
- STAGE_GAP, 4: cycles between successive domain releases; must be ≥ 1.
- INIT_TIMEOUT, 256: maximum cycles spent waiting for i_mem_init_done; must be ≥ 1.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset; also the external/POR reset request.
- i_sw_reset_req  in  1  software reset request; single-cycle pulse from CP15 write.
- i_wdt_reset_req  in  1  watchdog reset request; level, may be held.
- i_mem_init_done  in  1  cache/TLB invalidate complete; level, sampled only in WAIT_INIT.
- o_reset_periph  out  1  peripheral domain reset, active high.
- o_reset_mem  out  1  cache/MMU domain reset, active high.
- o_reset_core  out  1  core pipeline reset, active high.
- o_busy  out  1  high whenever state ≠ RUN.
- o_reset_cause  out  2  cause of last reset: 01 external, 10 software, 11 watchdog; 00 is never produced after reset.
- o_init_err  out  1  sticky; set if INIT_TIMEOUT expired in the last sequence.

## Operation
- Reset is synchronous and active-high on i_reset.
- Reset values: all three o_reset_* = 1, o_busy = 1, o_reset_cause = 01, o_init_err = 0, state ASSERT, counter 0.
- "Request" means any of i_reset, i_sw_reset_req or i_wdt_reset_req sampled high.
  - In any state, a request forces the following at the next edge: state ASSERT, counter 0, all o_reset_* = 1, o_init_err = 0.
  - Cause priority: i_reset > wdt > sw.
  - o_reset_cause updates only on a request edge and holds otherwise.
- States: ASSERT → REL_MEM → WAIT_INIT → REL_CORE → RUN. Transitions below use the counter value before the edge.
  - ASSERT: if a request is sampled, counter = 0. Otherwise counter++. When counter = MIN_ASSERT−1: o_reset_periph ← 0, counter ← 0, go to REL_MEM.
  - REL_MEM: counter++. When counter = STAGE_GAP−1: o_reset_mem ← 0, counter ← 0, go to WAIT_INIT.
  - WAIT_INIT: counter++. When i_mem_init_done = 1, or counter = INIT_TIMEOUT−1, go to REL_CORE with counter ← 0. On the timeout path with done low, o_init_err ← 1.
  - REL_CORE: counter++. When counter = STAGE_GAP−1: o_reset_core ← 0, counter ← 0, go to RUN.
  - RUN: all o_reset_* = 0; counter idle. Only a request leaves RUN.
- A held i_wdt_reset_req, or a held i_reset, keeps the block in ASSERT with counter 0. Counting starts on the first edge after the request drops.
- The counter width must hold max(MIN_ASSERT, STAGE_GAP, INIT_TIMEOUT)−1. No wrap occurs within any state.
- Release order is always periph, then mem, then core. The core is never out of reset while mem or periph is in reset.

## Timing
- All outputs are registered and there is no combinational input→output path.
- Request to assertion: at most 1 edge. Request sampled at edge 0 means all o_reset_* are 1 after edge 0.
- Number edges k = 1, 2, … starting at the first edge with no request sampled:
  - o_reset_periph falls at edge MIN_ASSERT.
  - o_reset_mem falls at edge MIN_ASSERT+STAGE_GAP.
- If i_mem_init_done is sampled high at WAIT_INIT edge t, o_reset_core falls at edge t+STAGE_GAP.
- i_mem_init_done already high on entry to WAIT_INIT is accepted at the first WAIT_INIT edge (edge MIN_ASSERT+STAGE_GAP+1).
- o_busy falls on the same edge as o_reset_core.
- If a request and the final release coincide on the same edge, the request wins.

## Test plan
- i_reset high for 3 cycles, then low; i_mem_init_done tied high; defaults. Required: periph falls at k=8, mem at k=12, core and busy at k=17, cause = 01, init_err = 0.
- In RUN, a 1-cycle i_sw_reset_req. Required: all resets high next edge, cause = 10, then the same 8/12/17 release schedule counted from the pulse's following edge.
- i_wdt_reset_req held 20 cycles during REL_MEM. Required: all resets high and stay high for the full 20 cycles; cause = 11; periph falls 8 edges after the level drops.
- i_mem_init_done held low, INIT_TIMEOUT = 16. Required: core falls 16+4 edges after WAIT_INIT entry; init_err = 1. A subsequent sw request clears init_err.
- i_reset, i_wdt_reset_req and i_sw_reset_req all high on the same edge. Required: cause = 01. Next, wdt and sw together give cause = 11.
- In WAIT_INIT, i_mem_init_done pulses 1 cycle at t = 5 after entry. Required: core falls exactly STAGE_GAP edges later; the pulse is ignored if it arrives during ASSERT or REL_MEM.
